// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control inputs and status outputs of the down counter timer
interface down_counter_timer_if #(parameter int N = 8);
  logic t;
  logic load;
  logic [N-1:0] load_val;
  logic auto_reload;
  logic [N-1:0] q;
  logic [N-1:0] qbar;
  logic tc;
  logic busy;
  logic done;
  modport master(output t, load, load_val, auto_reload, input q, qbar, tc, busy, done);
  modport slave(input t, load, load_val, auto_reload, output q, qbar, tc, busy, done);
endinterface

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter with one-shot/periodic modes and a one-cycle terminal-count pulse
module down_counter_timer #(parameter int N = 8) (
  input logic clk,
  input logic rst,
  down_counter_timer_if.slave b
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_d;
  logic [N-1:0] q_r, q_d, rl, rl_d;
  logic tc, tc_d;
  logic last;
  assign last = q_r <= N'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      q_r <= '0;
      rl <= '0;
      tc <= 1'b0;
    end else begin
      state <= state_d;
      q_r <= q_d;
      rl <= rl_d;
      tc <= tc_d;
    end
  // load wins over counting; auto_reload only matters on the terminal edge
  always_comb begin
    state_d = state;
    q_d = q_r;
    rl_d = rl;
    tc_d = 1'b0;
    if (b.load) begin
      q_d = b.load_val;
      rl_d = b.load_val;
      state_d = b.load_val != '0 ? RUN : IDLE;
    end else if (state == RUN && b.t) begin
      tc_d = last;
      q_d = !last ? q_r - N'(1) : (b.auto_reload ? rl : '0);
      state_d = last && !b.auto_reload ? DONE : RUN;
    end
  end
  assign b.q = q_r;
  assign b.qbar = ~q_r;
  assign b.tc = tc;
  assign b.busy = state == RUN;
  assign b.done = state == DONE;
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: randomized and directed scoreboard bench for down_counter_timer
module tb_down_counter_timer;
  logic clk = 1'b0;
  logic rst;
  down_counter_timer_if #(.N(8)) b();
  down_counter_timer #(.N(8)) dut(.clk(clk), .rst(rst), .b(b));
  always #5 clk = ~clk;
  typedef struct {logic [7:0] q; logic tc; logic busy; logic done; string tag;} exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int m_count, m_period, m_mode;
  bit m_pulse;
  string tag;
  function automatic void model_reset();
    m_count = 0;
    m_period = 0;
    m_mode = 0;
    m_pulse = 0;
  endfunction
  // m_mode: 0 idle, 1 counting, 2 finished
  function automatic void model_step(bit t, bit ld, int lv, bit ar);
    m_pulse = 0;
    if (ld) begin
      m_count = lv;
      m_period = lv;
      m_mode = lv != 0 ? 1 : 0;
    end else if (m_mode == 1 && t) begin
      if (m_count == 1) begin
        m_pulse = 1;
        m_count = ar ? m_period : 0;
        if (!ar) m_mode = 2;
      end else m_count = m_count - 1;
    end
  endfunction
  task automatic drive(bit t, bit ld, logic [7:0] lv, bit ar);
    exp_t e;
    b.t = t;
    b.load = ld;
    b.load_val = lv;
    b.auto_reload = ar;
    @(posedge clk);
    #1;
    model_step(t, ld, int'(lv), ar);
    e.q = 8'(m_count);
    e.tc = m_pulse;
    e.busy = m_mode == 1;
    e.done = m_mode == 2;
    e.tag = tag;
    sb.push_back(e);
  endtask
  task automatic chk_now(string n, logic [7:0] q, logic tc, logic busy, logic done);
    checks++;
    if (b.q !== q || b.qbar !== ~q || b.tc !== tc || b.busy !== busy || b.done !== done) begin
      errors++;
      $display("FAIL %s: got q=%h qbar=%h tc=%b busy=%b done=%b, want q=%h qbar=%h tc=%b busy=%b done=%b",
               n, b.q, b.qbar, b.tc, b.busy, b.done, q, ~q, tc, busy, done);
    end
  endtask
  initial begin
    int tc_at;
    exp_t e;
    rst = 1'b0;
    b.t = 0;
    b.load = 0;
    b.load_val = '0;
    b.auto_reload = 0;
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++;
          if (b.q !== e.q || b.qbar !== ~e.q || b.tc !== e.tc || b.busy !== e.busy || b.done !== e.done) begin
            errors++;
            $display("FAIL %s: got q=%h qbar=%h tc=%b busy=%b done=%b, want q=%h qbar=%h tc=%b busy=%b done=%b",
                     e.tag, b.q, b.qbar, b.tc, b.busy, b.done, e.q, ~e.q, e.tc, e.busy, e.done);
          end
        end
      end
    join_none
    #2;
    chk_now("reset_no_clock", 8'h00, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tag = "idle_after_reset";
    repeat (3) drive(1, 0, 8'h00, 0);
    tag = "oneshot_5";
    drive(0, 1, 8'h05, 0);
    repeat (8) drive(1, 0, 8'h00, 0);
    tag = "periodic_3";
    drive(0, 1, 8'h03, 1);
    repeat (10) drive(1, 0, 8'h00, 1);
    tag = "ar_ignored_midcount";
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 1);
    tag = "t_pattern";
    drive(0, 1, 8'h04, 0);
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    tag = "load_priority";
    drive(0, 1, 8'h01, 0);
    drive(1, 1, 8'h09, 0);
    drive(1, 1, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    tag = "load_1_oneshot";
    drive(0, 1, 8'h01, 0);
    drive(1, 0, 8'h00, 0);
    drive(1, 0, 8'h00, 0);
    tag = "random";
    for (int i = 0; i < 400; i++) begin
      bit ld;
      logic [7:0] lv;
      ld = $urandom_range(0, 9) == 0;
      lv = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'($urandom_range(0, 5));
      drive(1'($urandom), ld, lv, 1'($urandom));
    end
    tag = "reach_0x40";
    drive(0, 1, 8'h50, 0);
    repeat (16) drive(1, 0, 8'h00, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    #1;
    chk_now("async_reset_midcount", 8'h00, 0, 0, 0);
    @(negedge clk);
    chk_now("reset_held_no_tc", 8'h00, 0, 0, 0);
    rst = 1'b1;
    tag = "count_255";
    drive(1, 1, 8'hFF, 0);
    tc_at = -1;
    for (int i = 1; i <= 300; i++) begin
      drive(1, 0, 8'h00, 0);
      if (tc_at < 0 && b.tc === 1'b1) tc_at = i;
    end
    checks++;
    if (tc_at != 255) begin
      errors++;
      $display("FAIL tc_latency_255: got %0d edges, want 255", tc_at);
    end
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter: N, default 8, counter width in bits; legal values N >= 2.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-low.
REQ-004 Port: t  input  1  count enable; one decrement per clk edge while high in RUN.
REQ-005 Port: load  input  1  synchronous load strobe.
REQ-006 Port: load_val  input  N  value captured on load.
REQ-007 Port: auto_reload  input  1  1 = periodic mode, 0 = one-shot mode.
REQ-008 Port: q  output  N  current count, registered.
REQ-009 Port: qbar  output  N  bitwise complement of q.
REQ-010 Port: tc  output  1  terminal-count pulse, registered, one clk wide.
REQ-011 Port: busy  output  1  high in RUN state.
REQ-012 Port: done  output  1  high in DONE state.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, RUN, DONE; busy = (state == RUN) and done = (state == DONE).
REQ-014 The block SHALL hold qbar == ~q at all times, including during reset.
REQ-015 On a clk edge with load=1 in any state, the block SHALL set q <= load_val and reload_reg <= load_val, and SHALL force tc <= 0.
REQ-016 On that load edge, the next state SHALL be RUN if load_val != 0, else IDLE.
REQ-017 Load SHALL take priority over counting and over terminal-count detection on the same edge.
REQ-018 In RUN with load=0 and t=0, the block SHALL hold q and the state, with tc <= 0.
REQ-019 In RUN with load=0, t=1 and q > 1, the block SHALL set q <= q - 1 and tc <= 0.
REQ-020 In RUN with load=0, t=1, q == 1 and auto_reload=0, the block SHALL set q <= 0, tc <= 1 and state <= DONE.
REQ-021 In RUN with load=0, t=1, q == 1 and auto_reload=1, the block SHALL set q <= reload_reg, tc <= 1 and remain in RUN; the period is therefore reload_reg enabled cycles.
REQ-022 auto_reload SHALL be sampled only on the terminal edge; changing it at any other time SHALL have no effect.
REQ-023 In IDLE and DONE, t SHALL be ignored: q holds, tc = 0, and the count never wraps below 0.
REQ-024 DONE SHALL persist until the next load or reset.
REQ-025 tc SHALL be high for exactly the one cycle following the terminal edge.

Reset
REQ-026 While rst=0, the block SHALL immediately, without a clock, force: q = 0, qbar = all ones, tc = 0, busy = 0, done = 0, reload_reg = 0, state = IDLE.
REQ-027 Reset asserted mid-count SHALL abort the count, with no tc pulse generated.
REQ-028 After rst deasserts, the block SHALL stay in IDLE until the first load edge.

Verification (N = 8)
REQ-029 Assert rst=0 with clk stopped -> q=0x00, qbar=0xFF, tc=0, busy=0, done=0.
REQ-030 Load 0x05 with auto_reload=0, then hold t=1 -> q 5,4,3,2,1,0 on successive edges; tc=1 only in the cycle q becomes 0; then done=1, busy=0; further t leaves q=0.
REQ-031 Load 0x03 with auto_reload=1, then hold t=1 -> q 3,2,1,3,2,1,...; tc pulses every 3rd cycle; busy stays 1.
REQ-032 Load 0x04, then apply t pattern 1,0,0,1 -> q 3,3,3,2; tc=0 throughout.
REQ-033 With q=0x01, t=1, load=1 and load_val=0x09 on the same edge -> q=0x09, tc=0, state RUN; load 0x00 -> IDLE, q=0, no tc.
REQ-034 At q=0x40 in RUN, assert rst=0 between edges -> q=0x00 immediately; after release, load 0xFF with t=1 -> tc occurs exactly 255 edges later.
